// File: rtl/fractcam_pkg.sv
// Shared definitions for the fractional TCAM write path.
// - SLICE_WIDTH_DEFAULT : key bits covered by one LUTRAM slice.
// - ceil_div()          : integer ceiling divide, used to size SLICE_COUNT.
// - STATE_IDLE/WRITE    : state encodings of the write controller.
package fractcam_pkg;

  localparam int SLICE_WIDTH_DEFAULT = 5;

  localparam logic STATE_IDLE  = 1'b0;
  localparam logic STATE_WRITE = 1'b1;

  typedef enum logic {
    ST_IDLE  = STATE_IDLE,
    ST_WRITE = STATE_WRITE
  } state_e;

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/fractcam_wr_ctrl_if.sv
// Entry-update request channel of the fractional TCAM write controller.
// - valid/ready : handshake; a request transfers when both are high at a clock edge.
// - entry       : target entry index.
// - key / mask  : key value and care mask (1 = compare, 0 = wildcard).
// - enable      : 1 = program the entry, 0 = invalidate it.
// master drives the request, slave (the controller) drives ready.
interface fractcam_wr_ctrl_if #(
  parameter int ENTRY_ADDR_WIDTH = 4,
  parameter int KEY_WIDTH        = 32
);

  logic                        valid;
  logic                        ready;
  logic [ENTRY_ADDR_WIDTH-1:0] entry;
  logic [KEY_WIDTH-1:0]        key;
  logic [KEY_WIDTH-1:0]        mask;
  logic                        enable;

  modport master (output valid, entry, key, mask, enable, input ready);
  modport slave  (input valid, entry, key, mask, enable, output ready);

endinterface

// File: rtl/fractcam_slice_match.sv
// Combinational LUTRAM content generator for one TCAM entry.
// - addr  : LUTRAM address (the slice's key bits being looked up).
// - key   : padded key, SLICE_COUNT*SLICE_WIDTH bits.
// - mask  : padded care mask, same width; pad bits must be 0.
// - match : one bit per slice, 1 when addr equals the key on every cared bit.
module fractcam_slice_match
  import fractcam_pkg::*;
#(
  parameter int SLICE_WIDTH = SLICE_WIDTH_DEFAULT,
  parameter int SLICE_COUNT = 1
) (
  input  logic [SLICE_WIDTH-1:0]             addr,
  input  logic [SLICE_COUNT*SLICE_WIDTH-1:0] key,
  input  logic [SLICE_COUNT*SLICE_WIDTH-1:0] mask,
  output logic [SLICE_COUNT-1:0]             match
);

  // NOTE: every signal written in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    match = '0;
    for (int i = 0; i < SLICE_COUNT; i++) begin
      match[i] = ((addr ^ key[i*SLICE_WIDTH +: SLICE_WIDTH])
                  & mask[i*SLICE_WIDTH +: SLICE_WIDTH]) == '0;
    end
  end

endmodule

// File: rtl/fractcam_wr_ctrl.sv
// Fractional TCAM write controller, upstream of the entry-select demux.
// Accepts one entry update over s_wr, then rewrites all 2^SLICE_WIDTH
// LUTRAM addresses of every slice of that entry, one address per cycle.
// - clk, rst_n : clock, asynchronous active-low reset.
// - s_wr       : request channel (slave side).
// - wr_en      : LUTRAM write strobe.
// - wr_addr    : LUTRAM address being written (also the burst counter).
// - wr_sel     : entry index, demux select.
// - wr_data    : match bit per slice, demux data.
// - wr_last    : marks the final address of the burst.
// - busy       : update in progress.
module fractcam_wr_ctrl
  import fractcam_pkg::*;
#(
  parameter int KEY_WIDTH        = 32,
  parameter int SLICE_WIDTH      = SLICE_WIDTH_DEFAULT,
  parameter int SLICE_COUNT      = ceil_div(KEY_WIDTH, SLICE_WIDTH),
  parameter int ENTRY_COUNT      = 16,
  parameter int ENTRY_ADDR_WIDTH = $clog2(ENTRY_COUNT)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  fractcam_wr_ctrl_if.slave           s_wr,
  output logic                        wr_en,
  output logic [SLICE_WIDTH-1:0]      wr_addr,
  output logic [ENTRY_ADDR_WIDTH-1:0] wr_sel,
  output logic [SLICE_COUNT-1:0]      wr_data,
  output logic                        wr_last,
  output logic                        busy
);

  localparam int                     PAD_WIDTH = SLICE_COUNT * SLICE_WIDTH;
  localparam logic [SLICE_WIDTH-1:0] ADDR_LAST = '1;

  state_e                 state_q, state_d;
  logic                   ready_q;
  logic                   en_q, en_d;
  logic [PAD_WIDTH-1:0]   key_q, key_d;
  logic [PAD_WIDTH-1:0]   mask_q, mask_d;
  logic                   load;
  logic                   wr_en_d, wr_last_d;
  logic [SLICE_WIDTH-1:0] addr_d;
  logic [SLICE_COUNT-1:0] match;

  assign s_wr.ready = ready_q;
  assign busy       = (state_q == ST_WRITE);

  // Outputs are registered, so the match is evaluated on the values the
  // registers are about to take: on the accepting edge that is the incoming
  // request, afterwards the latched copy. Zero-extension makes pad bits
  // wildcards.
  assign key_d  = load ? PAD_WIDTH'(s_wr.key)  : key_q;
  assign mask_d = load ? PAD_WIDTH'(s_wr.mask) : mask_q;
  assign en_d   = load ? s_wr.enable           : en_q;

  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    wr_en_d   = 1'b0;
    wr_last_d = 1'b0;
    addr_d    = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (s_wr.valid && ready_q) begin
          load    = 1'b1;
          state_d = ST_WRITE;
          wr_en_d = 1'b1;
        end
      end
      ST_WRITE: begin
        // Terminal count alone ends the burst; the counter never wraps.
        if (wr_addr == ADDR_LAST) begin
          state_d = ST_IDLE;
        end else begin
          wr_en_d   = 1'b1;
          addr_d    = wr_addr + SLICE_WIDTH'(1);
          wr_last_d = (addr_d == ADDR_LAST);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  fractcam_slice_match #(
    .SLICE_WIDTH (SLICE_WIDTH),
    .SLICE_COUNT (SLICE_COUNT)
  ) u_match (
    .addr  (addr_d),
    .key   (key_d),
    .mask  (mask_d),
    .match (match)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b0;
      en_q    <= 1'b0;
      key_q   <= '0;
      mask_q  <= '0;
      wr_en   <= 1'b0;
      wr_last <= 1'b0;
      wr_addr <= '0;
      wr_sel  <= '0;
      wr_data <= '0;
    end else begin
      state_q <= state_d;
      // Ready stays low through reset and rises on the first edge after it.
      ready_q <= (state_d == ST_IDLE);
      en_q    <= en_d;
      key_q   <= key_d;
      mask_q  <= mask_d;
      wr_en   <= wr_en_d;
      wr_last <= wr_last_d;
      wr_addr <= addr_d;
      wr_data <= wr_en_d ? (match & {SLICE_COUNT{en_d}}) : '0;
      if (load) begin
        wr_sel <= s_wr.entry;
      end
    end
  end

endmodule

// File: doc/fractcam_wr_ctrl.md
Name: fractcam_wr_ctrl

Overview:
- Sequential write controller placed directly upstream of the entry-select demux in the fractional TCAM.
- Accepts one entry-update request (entry index, key, care-mask, valid flag) through a valid/ready handshake.
- Rewrites every LUTRAM address of every key slice for that entry, one address per cycle.
- Emits the per-slice match bits as data, the entry index as select, and the LUT address plus write enable alongside.

Parameters:
- KEY_WIDTH, 32, search key width in bits.
- SLICE_WIDTH, 5, key bits per LUTRAM slice; each slice has 2^SLICE_WIDTH addresses.
- SLICE_COUNT, ceil(KEY_WIDTH/SLICE_WIDTH), number of slices per entry.
- ENTRY_COUNT, 16, number of TCAM entries.
- ENTRY_ADDR_WIDTH, $clog2(ENTRY_COUNT), width of the entry index.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- s_wr_valid  in  1  request valid.
- s_wr_ready  out  1  request ready.
- s_wr_entry  in  ENTRY_ADDR_WIDTH  target entry index.
- s_wr_key  in  KEY_WIDTH  key value.
- s_wr_mask  in  KEY_WIDTH  care mask; 1 = compare, 0 = wildcard.
- s_wr_enable  in  1  1 = program the entry, 0 = invalidate it (never match).
- wr_en  out  1  LUTRAM write strobe.
- wr_addr  out  SLICE_WIDTH  LUTRAM address being written.
- wr_sel  out  ENTRY_ADDR_WIDTH  entry index; drives the demux select.
- wr_data  out  SLICE_COUNT  match bit per slice; drives the demux data input.
- wr_last  out  1  high together with wr_en on the final address.
- busy  out  1  update in progress.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State = IDLE; counter = 0.
  - wr_en, wr_last, busy, wr_addr, wr_sel and wr_data all 0.
  - s_wr_ready = 0 while in reset, then 1 from the first clk edge after deassertion.
- All write-side outputs are registered.
- Padding: the key and mask are zero-extended to SLICE_COUNT*SLICE_WIDTH bits. Pad bits are therefore wildcards and always match.
- Match rule for slice i at address a: wr_data[i] = en_q && (((a ^ key_q[i]) & mask_q[i]) == 0).
- IDLE state:
  - s_wr_ready = 1, busy = 0.
  - A handshake (valid && ready) at edge T latches entry, key, mask and enable; state moves to WRITE and the counter is cleared.
- WRITE state:
  - s_wr_ready = 0, busy = 1.
  - The outputs present in cycle T+1+k are wr_en=1, wr_addr=k and wr_sel=entry_q, for k = 0 .. 2^SLICE_WIDTH-1.
  - The counter increments every cycle. There is no stall input; the downstream side always accepts writes.
  - wr_last=1 in the cycle where k = 2^SLICE_WIDTH-1.
  - The next edge returns to IDLE: wr_en=0, busy=0, s_wr_ready=1.
- Throughput: one request per 2^SLICE_WIDTH+1 cycles.
- Requests presented while busy are held off by ready=0; the request fields are not sampled.
- Counter wrap: the counter never wraps inside a request. The terminal count alone ends the WRITE state.
- Reset during WRITE:
  - wr_en drops asynchronously.
  - The partially written entry is undefined; software must reissue the request.
- s_wr_entry values at or above ENTRY_COUNT are forwarded unchanged; the downstream demux drops them.
- The latched fields are stable for the whole WRITE period.

Decomposition:
- Shared package fractcam_pkg holds:
  - SLICE_WIDTH default;
  - a ceil-divide function for SLICE_COUNT;
  - FSM state encoding localparams (IDLE=0, WRITE=1).
- One combinational sub-module, fractcam_slice_match: inputs are addr, padded key and padded mask; output is the SLICE_COUNT match vector. It is instantiated once in the controller and is reusable by a read-back checker.

Test Plan:
Configuration for all scenarios: KEY_WIDTH=10, SLICE_WIDTH=5, ENTRY_COUNT=4, so SLICE_COUNT=2.
- Reset and idle: assert rst_n=0 mid-cycle -> all outputs 0 immediately; after release, s_wr_ready=1, wr_en=0.
- Exact match: entry=2, key=0x3A5 (slice0=0x05, slice1=0x1D), mask=0x3FF, enable=1 ->
  - 32 cycles of wr_en with wr_sel=2 and wr_addr 0..31;
  - wr_data[0]=1 only at addr 5, wr_data[1]=1 only at addr 29;
  - wr_last only at addr 31; ready returns the next cycle.
- Wildcards: mask=0x000, any key -> wr_data=2'b11 at all 32 addresses. With slice0 mask=0x1E and key=0x04 -> wr_data[0]=1 at addr 4 and addr 5 only.
- Invalidate: enable=0, key=0x3A5, mask=0x3FF -> wr_data=2'b00 for all 32 writes, wr_sel=entry.
- Back-pressure: hold s_wr_valid=1 with a second request (entry=1) during WRITE ->
  - not accepted before wr_last;
  - accepted on the first IDLE edge;
  - second burst starts exactly 33 cycles after the first handshake.
- Reset mid-write: pull rst_n low at wr_addr=10 -> wr_en falls without waiting for a clock edge; after release the block is in IDLE with ready=1, and a new request produces a full 32-address burst starting at addr 0.
